// File: rtl/ram_dp_clear.sv
// Simple-dual-port RAM with a built-in clear engine.
// One write port and one registered read port share a single clock. After reset
// release, and again on clr_req, the clear engine sweeps every word to CLEAR_VALUE
// through the write port while user accesses are blocked.
// Optional macro RAM_BYPASS_EN: a same-cycle write and read to the same address
// returns the new write data (write-first). Without it the old word is returned.
module ram_dp_clear #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned CLEAR_VALUE = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clr_req,
    output logic                  clr_busy,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid
);

    localparam int unsigned           Depth     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LastAddr  = ADDR_WIDTH'(Depth - 1);
    localparam logic [DATA_WIDTH-1:0] ClearWord = DATA_WIDTH'(CLEAR_VALUE);

    typedef enum logic [0:0] {
        StClear,
        StIdle
    } state_e;

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   clr_cnt_q;
    logic                    busy_q;

    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH-1:0]   mem_q [Depth];

    logic                    rd_fire;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic [DATA_WIDTH-1:0]   rd_data_q;
    logic                    rd_valid_q;

    // Clear FSM: sweep DEPTH words once, then idle until the next clr_req.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StClear;
            clr_cnt_q <= '0;
            busy_q    <= 1'b1;
        end else begin
            unique case (state_q)
                StClear: begin
                    // clr_req is deliberately ignored here: no restart, no queuing.
                    clr_cnt_q <= clr_cnt_q + 1'b1;
                    if (clr_cnt_q == LastAddr) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                StIdle: begin
                    if (clr_req) begin
                        state_q   <= StClear;
                        clr_cnt_q <= '0;
                        busy_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= StClear;
                    clr_cnt_q <= '0;
                    busy_q    <= 1'b1;
                end
            endcase
        end
    end

    // Single write port, owned by the clear engine while sweeping.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        if (state_q == StClear) begin
            mem_we    = 1'b1;
            mem_waddr = clr_cnt_q;
            mem_wdata = ClearWord;
        end else if (wr_en) begin
            mem_we = 1'b1;
        end
    end

    // Storage array; contents are untouched by reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign rd_fire = rd_en && (state_q == StIdle);

    // Read word selection; forwarding only matters when the write lands this cycle.
    always_comb begin
`ifdef RAM_BYPASS_EN
        rd_word = mem_q[rd_addr];
        if (wr_en && (wr_addr == rd_addr)) begin
            rd_word = wr_data;
        end
`else
        rd_word = mem_q[rd_addr];
`endif
    end

    // Registered read port; data holds when no read fires.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_fire;
            if (rd_fire) begin
                rd_data_q <= rd_word;
            end
        end
    end

    assign clr_busy = busy_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_ram_dp_clear.sv
// Directed self-checking bench for ram_dp_clear (DEPTH=16, DATA_WIDTH=8, CLEAR_VALUE=A5).
module tb_ram_dp_clear;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          clr_req = 1'b0;
    logic          clr_busy;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;

    int tests = 0;
    int fails = 0;
    int n;

    ram_dp_clear #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .CLEAR_VALUE('hA5)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_req (clr_req),
        .clr_busy(clr_busy),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .rd_valid(rd_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Counts cycles with clr_busy high, starting from the current negedge sample.
    task automatic count_busy(output int cnt);
        cnt = 0;
        while (clr_busy && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Single read: valid pulse with data, then valid low with data held.
    task automatic do_read(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        rd_en   = 1'b1;
        rd_addr = a;
        @(negedge clk);
        rd_en = 1'b0;
        check({tag, " valid"}, 32'(rd_valid), 32'd1);
        check({tag, " data"}, 32'(rd_data), 32'(exp));
        @(negedge clk);
        check({tag, " valid_drop"}, 32'(rd_valid), 32'd0);
        check({tag, " hold"}, 32'(rd_data), 32'(exp));
    endtask

    initial begin
        // Reset state
        #12;
        check("rst rd_data", 32'(rd_data), 32'h0);
        check("rst rd_valid", 32'(rd_valid), 32'd0);
        check("rst clr_busy", 32'(clr_busy), 32'd1);

        // Reset release: busy for exactly 16 cycles
        @(negedge clk);
        reset_n = 1'b1;
        count_busy(n);
        check("post-reset busy cycles", 32'(n), 32'd16);
        for (int i = 0; i < 16; i++) begin
            do_read($sformatf("clr rd%0d", i), AW'(i), 8'hA5);
        end

        // Write then read
        do_write(4'd7, 8'h3C);
        do_read("wr7 rd7", 4'd7, 8'h3C);

        // Same-cycle collision on addr 2
        do_write(4'd2, 8'h11);
        wr_en   = 1'b1;
        wr_addr = 4'd2;
        wr_data = 8'h22;
        rd_en   = 1'b1;
        rd_addr = 4'd2;
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("collide valid", 32'(rd_valid), 32'd1);
`ifdef RAM_BYPASS_EN
        check("collide data", 32'(rd_data), 32'h22);
`else
        check("collide data", 32'(rd_data), 32'h11);
`endif
        @(negedge clk);
        do_read("collide follow", 4'd2, 8'h22);

        // Streaming reads after writing data = addr+1
        for (int i = 0; i < 16; i++) begin
            do_write(AW'(i), DW'(i + 1));
        end
        rd_en   = 1'b1;
        rd_addr = 4'd0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            rd_addr = AW'(i + 1);
            check($sformatf("stream valid%0d", i), 32'(rd_valid), 32'd1);
            check($sformatf("stream data%0d", i), 32'(rd_data), 32'(i + 1));
        end
        rd_en = 1'b0;
        @(negedge clk);
        check("stream end valid", 32'(rd_valid), 32'd0);

        // Accesses and a second clr_req during clear
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        check("clr_req busy", 32'(clr_busy), 32'd1);
        n = 0;
        repeat (3) begin
            @(negedge clk);
            n++;
        end
        wr_en   = 1'b1;
        wr_addr = 4'd15;
        wr_data = 8'hFF;
        rd_en   = 1'b1;
        rd_addr = 4'd0;
        @(negedge clk);
        n++;
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("clear rd_valid", 32'(rd_valid), 32'd0);
        check("clear rd hold", 32'(rd_data), 32'h10);
        @(negedge clk);
        n++;
        clr_req = 1'b1;
        @(negedge clk);
        n++;
        clr_req = 1'b0;
        while (clr_busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("clear busy cycles", 32'(n), 32'd16);
        do_read("clear addr15", 4'd15, 8'hA5);
        do_read("clear addr7", 4'd7, 8'hA5);

        // Reset mid-read
        rd_en   = 1'b1;
        rd_addr = 4'd3;
        @(negedge clk);
        check("midread valid", 32'(rd_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        check("midread rst valid", 32'(rd_valid), 32'd0);
        check("midread rst data", 32'(rd_data), 32'h0);
        check("midread rst busy", 32'(clr_busy), 32'd1);
        rd_en = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        count_busy(n);
        check("midread busy cycles", 32'(n), 32'd16);

        // Reset mid-clear at clear cycle 8
        do_write(4'd9, 8'h5A);
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        repeat (8) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midclr rst busy", 32'(clr_busy), 32'd1);
        check("midclr rst valid", 32'(rd_valid), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        count_busy(n);
        check("midclr busy cycles", 32'(n), 32'd16);
        do_read("midclr addr9", 4'd9, 8'hA5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Watchdog keeps the run bounded no matter what the DUT does.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ram_dp_clear.md
Name: ram_dp_clear

Overview:
- Parametrised simple-dual-port RAM: one write port, one registered read port, on a single clock.
- Built-in clear engine sweeps every word to CLEAR_VALUE automatically after reset and again on request. This replaces the simulation-only initial-block init used by the older RAM, so the clear also happens in hardware.
- Serves wavetable, voice-state and envelope storage across the synth datapath.

Parameters:
- ADDR_WIDTH, 8, address bits; DEPTH = 2**ADDR_WIDTH words.
- DATA_WIDTH, 8, bits per word.
- CLEAR_VALUE, 0, word value written by the clear engine, truncated to DATA_WIDTH.

Ports:
- clk  input  1  single system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- clr_req  input  1  single-cycle request to re-clear the whole memory.
- clr_busy  output  1  high while the clear engine owns the array.
- wr_en  input  1  write strobe.
- wr_addr  input  ADDR_WIDTH  write address.
- wr_data  input  DATA_WIDTH  write data.
- rd_en  input  1  read strobe.
- rd_addr  input  ADDR_WIDTH  read address.
- rd_data  output  DATA_WIDTH  registered read data.
- rd_valid  output  1  one-cycle pulse, rd_data valid.

Behaviour:
- Reset: reset_n is asynchronous and active-low; one clock only.
  - While reset_n=0: rd_data=0, rd_valid=0, clr_busy=1, state=CLEAR, clr_cnt=0.
  - Array contents are not touched by reset itself.
- FSM states: CLEAR, IDLE.
  - CLEAR: each cycle writes CLEAR_VALUE to mem[clr_cnt], then clr_cnt increments.
  - CLEAR exit: on the cycle writing clr_cnt = DEPTH-1, go to IDLE next cycle. clr_busy falls with the IDLE entry.
  - Sweep length: exactly DEPTH cycles after reset release; no wrap, no repeat.
  - IDLE: if clr_req=1 on a rising edge, go to CLEAR with clr_cnt=0 and clr_busy=1 from the next cycle.
  - clr_req while in CLEAR is ignored; no restart, no queuing.
- Port access during CLEAR:
  - wr_en is ignored; no user write lands.
  - rd_en is ignored: rd_valid stays 0 and rd_data holds its last value.
- Write (IDLE): if wr_en=1 at a rising edge, mem[wr_addr] <= wr_data.
- Read (IDLE):
  - If rd_en=1 at edge N: rd_data = mem[rd_addr] and rd_valid=1 after edge N. Latency is 1 cycle.
  - If rd_en=0: rd_valid=0 and rd_data holds.
  - Back-to-back reads are allowed every cycle.
- Read/write same address, same cycle: without the optional feature, rd_data returns the pre-write (old) word.
- Read/write different addresses in the same cycle: fully independent.
- Address width: addresses are exactly ADDR_WIDTH bits, so there is no out-of-range access.
- Reset asserted mid-clear or mid-read:
  - rd_valid drops immediately.
  - A full DEPTH-cycle clear reruns after release.
- Array inference:
  - The read register must infer block RAM; no asynchronous read path.
  - The clear write shares the single write port, muxed by state.

Optional Feature:
- Macro: RAM_BYPASS_EN.
- Defined: a same-cycle write and read to the same address in IDLE return the new wr_data on rd_data, with the same 1-cycle latency (write-first forwarding).
- Undefined: returns the old word (read-first), as stated above.
- Either way, CLEAR behaviour is unchanged.

Test Plan:
All scenarios use ADDR_WIDTH=4 (DEPTH=16), DATA_WIDTH=8, CLEAR_VALUE=8'hA5.
- Reset release: clr_busy=1 for exactly 16 cycles, then 0. Reading addrs 0..15 then returns 8'hA5 each, with rd_valid one cycle after each rd_en.
- Write then read, IDLE: write 8'h3C to addr 7, read addr 7 next cycle. rd_data=8'h3C one cycle after rd_en; rd_valid is a single-cycle pulse.
- Same-cycle collision: mem[2]=8'h11, then in one cycle write 8'h22 to addr 2 and read addr 2.
  - Without RAM_BYPASS_EN: rd_data=8'h11.
  - With RAM_BYPASS_EN: rd_data=8'h22.
  - A follow-up read returns 8'h22 in both builds.
- Accesses during clear: pulse clr_req, then attempt a write of 8'hFF to addr 15 and a read of addr 0 at clear cycle 3.
  - rd_valid stays 0.
  - After clr_busy falls, addr 15 reads 8'hA5.
  - A second clr_req at clear cycle 5 does not extend busy beyond 16 cycles.
- Reset mid-clear: assert reset_n=0 at clear cycle 8.
  - rd_valid=0 and clr_busy=1 immediately.
  - After release, clr_busy stays high for 16 full cycles.
- Streaming reads: rd_en held high with rd_addr 0..15 for 16 consecutive cycles after writing data=addr+1. rd_valid stays high for 16 cycles and rd_data runs 1..16 in order.
